// File: rtl/fifo_arb_if.sv
// fifo_arb_if: bundles the requester-side and downstream-side handshake of fifo_arb.
//   valid_i/data_i/ready_i : NREQ requesters (payload k in data_i[k*WIDTH +: WIDTH])
//   valid_o/data_o/src_o   : registered beat towards the downstream queue
//   ready_o                : downstream accept
//   lock_i                 : per-requester grant hold (only with FIFO_ARB_LOCK_EN)
// Modports: slave = arbiter side, master = requesters + downstream side.
interface fifo_arb_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = 2
);
  logic [NREQ-1:0]       valid_i;
  logic [NREQ-1:0]       ready_i;
  logic [NREQ*WIDTH-1:0] data_i;
  logic                  valid_o;
  logic                  ready_o;
  logic [WIDTH-1:0]      data_o;
  logic [IDW-1:0]        src_o;
`ifdef FIFO_ARB_LOCK_EN
  logic [NREQ-1:0]       lock_i;

  modport slave  (input  valid_i, data_i, ready_o, lock_i,
                  output ready_i, valid_o, data_o, src_o);
  modport master (output valid_i, data_i, ready_o, lock_i,
                  input  ready_i, valid_o, data_o, src_o);
`else
  modport slave  (input  valid_i, data_i, ready_o,
                  output ready_i, valid_o, data_o, src_o);
  modport master (output valid_i, data_i, ready_o,
                  input  ready_i, valid_o, data_o, src_o);
`endif
endinterface

// File: rtl/fifo_arb.sv
// fifo_arb: round-robin arbiter of NREQ requesters into one registered output beat.
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-low
//   bus    : fifo_arb_if.slave (valid_i/data_i/ready_i, valid_o/data_o/src_o/ready_o, lock_i)
// Optional macro FIFO_ARB_LOCK_EN adds lock_i and a held flag that keeps the
// grant on the current requester while its lock bit accompanies each transfer.
module fifo_arb #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = 2
) (
  input  logic      clk,
  input  logic      reset,
  fifo_arb_if.slave bus
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   src_q, src_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
`ifdef FIFO_ARB_LOCK_EN
  logic             held_q, held_d;
`endif

  logic             open_c;
  logic             found_c;
  logic [NREQ-1:0]  grant_c;
  logic [IDW-1:0]   gidx_c;
  logic [IDW-1:0]   ptr_inc_c;
  logic [WIDTH-1:0] sel_c;

  // Register can take a beat when empty or draining this cycle; never in reset.
  assign open_c = reset && (!valid_q || bus.ready_o);

  // Round-robin search starting at ptr; a held lock makes only ptr eligible.
  always_comb begin
    int unsigned sum;
    logic [IDW-1:0] idx;
    logic elig;
    grant_c = '0;
    found_c = 1'b0;
    gidx_c  = '0;
    sum     = 0;
    idx     = '0;
    elig    = 1'b0;
    if (open_c) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        sum = 32'(ptr_q) + i;
        if (sum >= NREQ) sum = sum - NREQ;
        idx = IDW'(sum);
`ifdef FIFO_ARB_LOCK_EN
        elig = !held_q || (i == 0);
`else
        elig = 1'b1;
`endif
        if (!found_c && elig && bus.valid_i[idx]) begin
          found_c      = 1'b1;
          grant_c[idx] = 1'b1;
          gidx_c       = idx;
        end
      end
    end
  end

  // One-hot payload mux driven by the grant.
  always_comb begin
    sel_c = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant_c[k]) sel_c = sel_c | bus.data_i[k*WIDTH +: WIDTH];
    end
  end

  assign ptr_inc_c = (gidx_c == IDW'(NREQ - 1)) ? '0 : IDW'(gidx_c + 1'b1);

  // Next state: drain clears, a transfer loads (drain + load replaces in one edge).
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
`ifdef FIFO_ARB_LOCK_EN
    held_d  = held_q;
`endif
    if (valid_q && bus.ready_o) valid_d = 1'b0;
    if (found_c) begin
      valid_d = 1'b1;
      data_d  = sel_c;
      src_d   = gidx_c;
      ptr_d   = ptr_inc_c;
`ifdef FIFO_ARB_LOCK_EN
      held_d  = bus.lock_i[gidx_c];
      if (bus.lock_i[gidx_c]) ptr_d = gidx_c;
`endif
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
`ifdef FIFO_ARB_LOCK_EN
      held_q  <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
`ifdef FIFO_ARB_LOCK_EN
      held_q  <= held_d;
`endif
    end
  end

  assign bus.ready_i = grant_c;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.src_o   = src_q;

endmodule

// File: doc/fifo_arb.md
FIFO_ARB -- requirements
Module: fifo_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one downstream queue input (2..8).
REQ-002 Parameter WIDTH, default 32, payload width in bits.
REQ-003 Parameter IDW, default 2, requester-index width; SHALL equal clog2(NREQ).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 valid_i  input  NREQ  per-requester payload-valid.
REQ-007 ready_i  output  NREQ  per-requester accept; at most one bit set.
REQ-008 data_i  input  NREQ*WIDTH  requester k payload in bits [k*WIDTH +: WIDTH].
REQ-009 valid_o  output  1  registered output holds a beat.
REQ-010 ready_o  input  1  downstream (queue input ready) accepts the beat.
REQ-011 data_o  output  WIDTH  registered payload.
REQ-012 src_o  output  IDW  index of the requester that supplied data_o.
REQ-013 lock_i  input  NREQ  per-requester grant-hold request; present only when FIFO_ARB_LOCK_EN is defined.

Function
REQ-014 The block SHALL hold one output register (valid_o, data_o, src_o) and a round-robin pointer ptr (IDW bits).
REQ-015 The register SHALL be "open" when valid_o==0 or ready_o==1 in the current cycle.
REQ-016 When open, the block SHALL set ready_i[k]=1 only for the first k with valid_i[k]=1, searching ptr, ptr+1, ... modulo NREQ; all other bits SHALL be 0.
REQ-017 When not open, ready_i SHALL be all zeros.
REQ-018 ready_i SHALL depend combinationally on valid_i, ready_o, valid_o and ptr only, never on data_i.
REQ-019 On a transfer valid_i[k]&ready_i[k], the next edge SHALL load data_o=data_i[k], src_o=k, valid_o=1.
REQ-020 On a transfer from requester k, ptr SHALL become (k+1) mod NREQ, wrapping from NREQ-1 to 0.
REQ-021 Latency from an accepted input to valid_o SHALL be exactly 1 cycle.
REQ-022 If ready_o==1 and valid_o==1 with no new transfer, valid_o SHALL clear on the next edge.
REQ-023 Simultaneous output drain and input transfer SHALL replace the register in the same edge, giving 1 beat/cycle throughput.
REQ-024 While valid_o==1 and ready_o==0, data_o and src_o SHALL hold stable.
REQ-025 With no valid_i bits set, ptr SHALL hold its value.
REQ-026 A requester with valid_i held SHALL be granted within NREQ transfers (starvation-free).
REQ-027 Requesters SHALL keep valid_i and data_i stable until accepted; the block does not check this.

Reset
REQ-028 While reset==0 at an edge: valid_o=0, data_o=0, src_o=0, ptr=0, lock state cleared.
REQ-029 While reset==0, ready_i SHALL be all zeros.
REQ-030 Reset mid-operation SHALL discard any buffered beat without presenting it downstream.
REQ-031 The first cycle after reset release SHALL arbitrate normally, starting from ptr=0.

Configuration
REQ-032 Macro FIFO_ARB_LOCK_EN SHALL compile the lock feature in; when undefined, lock_i and all lock state SHALL be absent.
REQ-033 With FIFO_ARB_LOCK_EN, a transfer from k with lock_i[k]=1 SHALL set a held flag and hold ptr at k instead of advancing it.
REQ-034 With FIFO_ARB_LOCK_EN and the held flag set, only requester ptr SHALL be eligible for ready_i; others SHALL stall even if valid.
REQ-035 With FIFO_ARB_LOCK_EN, a transfer from the held requester with lock_i=0 SHALL clear the held flag and advance ptr per REQ-020.
REQ-036 Without FIFO_ARB_LOCK_EN, behaviour SHALL be pure round-robin per REQ-016..REQ-026.

Verification
REQ-037 Reset then valid_i=4'b1111, ready_o=1 held -> src_o sequence 0,1,2,3,0,... one beat per cycle, first valid_o one cycle after the first transfer.
REQ-038 valid_i=4'b1000 only, ready_o=1 -> ready_i=4'b1000 every cycle, ptr wraps 3->0, src_o=3 throughout.
REQ-039 Load data_i[1]=32'hDEAD_BEEF, then ready_o=0 for 5 cycles -> data_o=32'hDEAD_BEEF, src_o=1, valid_o=1 stable, ready_i=0; release ready_o -> one beat drained.
REQ-040 reset=0 asserted while valid_o=1 and ready_o=0 -> next cycle valid_o=0, ptr=0, beat never observed downstream.
REQ-041 FIFO_ARB_LOCK_EN defined: requester 2 sends 3 beats with lock_i[2]=1,1,0 while valid_i=4'b1111 -> src_o=2,2,2, then 3.
REQ-042 valid_i=4'b0101, ready_o toggling 1,0,1,0 -> grants alternate 0,2,0,2 with no beat lost or duplicated (scoreboard by src_o and payload).
